serial_receiver: RTL and testbench
==================================

// Module: serial_receiver
// PURPOSE
//  Receiving end of the single-wire serial link. Samples one bit per clk, deframes start/data/stop,
//  rebuilds {padding, packet} and holds it on receiver_* until the consumer flushes it.
//  Sits between the link wire and the router input buffer, in the same clock domain as the sender.
// PARAMETERS
//  PKT_W  42  packet payload width (bits)
//  PAD_W  4   padding/control field width (bits)
// PORTS
//  clk               in   1      rising-edge clock
//  rst               in   1      asynchronous, active-low reset (0 = reset)
//  serial_in         in   1      link wire; idles high
//  flush             in   1      consumer has taken the word; clears receiver_valid
//  receiver_valid    out  1      receiver_padding/receiver_packet hold a complete word
//  receiver_padding  out  PAD_W  received padding field
//  receiver_packet   out  PKT_W  received packet
//  frame_err         out  1      1-cycle pulse: stop bit sampled as 0
//  overrun           out  1      1-cycle pulse: frame completed while receiver_valid=1, frame dropped
//  parity_err        out  1      only with SERIAL_RX_PARITY_EN; 1-cycle pulse on parity mismatch
// BEHAVIOUR
//  - Frame on wire, one bit per clk: start(0), W=PAD_W+PKT_W data bits of {padding,packet} LSB first
//    (packet[0] first, padding[PAD_W-1] last), [parity], stop(1).
//  - FSM: IDLE -> DATA on serial_in==0; DATA counts W bits (cnt 0..W-1, width $clog2(W+1));
//    DATA -> PAR (macro on) or STOP after bit W-1; PAR -> STOP; STOP -> IDLE always.
//  - IDLE with serial_in==1 stays IDLE. No re-sync mid-frame: bits are taken blindly by count.
//  - Latency: stop bit sampled on edge N; receiver_valid/data updated on that same edge
//    (visible the following cycle). N = W+1 edges after start edge (W+2 with parity).
//  - Accept (stop==1, no parity error, receiver_valid==0 or flush==1): load shift reg into outputs, valid<=1.
//  - Stop==0: frame_err pulse, frame discarded, outputs unchanged, back to IDLE (line low ⇒ next start).
//  - Valid==1 and flush==0 at accept: overrun pulse, old word kept, new frame discarded.
//  - flush with no completing frame: valid<=0 next edge; data outputs keep last value.
//  - flush and accept same edge: new word loaded, valid stays 1 (flush consumed the old word).
//  - flush while valid==0: no effect.
//  - Shift register receives bits only in DATA; outputs never change mid-frame.
//  - Reset (any time, incl. mid-frame): state IDLE, cnt 0, shift reg 0, receiver_valid 0,
//    receiver_padding 0, receiver_packet 0, frame_err/overrun/parity_err 0.
//  - Error pulses are registered, exactly one cycle, mutually exclusive (priority: frame_err > parity_err > overrun).
// CONFIGURATION
//  SERIAL_RX_PARITY_EN defined: one even-parity bit follows the data (XOR of data bits ^ parity == 0);
//    mismatch ⇒ parity_err pulse at stop edge, frame discarded, outputs unchanged; frame is W+3 bits.
//  Undefined: no PAR state, no parity bit on wire, parity_err port absent; frame is W+2 bits.
// TESTING
//  1 reset: hold rst=0 with serial_in toggling -> all outputs 0, FSM IDLE; release -> no valid while line high.
//  2 frame padding=4'b1011 packet=42'h2AC19440329 -> receiver_valid 1 cycle after stop edge,
//    outputs equal sent values, no error pulses.
//  3 flush 1 cycle after (2), then same frame again -> valid drops next edge, rises again with identical data.
//  4 second frame 42'h0000000001/4'h0 without flush -> overrun pulses once, outputs still 42'h2AC19440329/4'b1011.
//  5 frame with stop bit 0 -> frame_err pulse, valid unchanged; next good frame received correctly.
//  6 rst=0 at data bit 20 then good frame -> clean reception; with SERIAL_RX_PARITY_EN, flipped parity -> parity_err, no valid.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver: receiving end of the single-wire serial link.
// It samples one bit per clk and deframes start(0), W = PAD_W+PKT_W data bits
// sent LSB first, an optional parity bit and stop(1). It then holds
// {padding, packet} on receiver_* until the consumer flushes the word.
// Optional feature: define SERIAL_RX_PARITY_EN to expect one even-parity bit
// after the data and to enable the parity_err port.
module serial_receiver #(
  parameter int PKT_W = 42,
  parameter int PAD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             flush,
  output logic             receiver_valid,
  output logic [PAD_W-1:0] receiver_padding,
  output logic [PKT_W-1:0] receiver_packet,
  output logic             frame_err,
  output logic             overrun
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int W     = PAD_W + PKT_W;
  localparam int CNT_W = $clog2(W + 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W-1:0]     r_shift;
  logic             w_shift_en;
  logic             w_stop_edge;
  logic             w_frame_bad;
  logic             w_par_bad;
  logic             w_good;
  logic             w_accept;
  logic             w_overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic             r_par_bit;
  logic             w_par_en;
`endif

  // State register and data-bit counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic and the decision taken on the stop-bit edge.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_stop_edge = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_par_en    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!serial_in) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        // Bits are taken blindly by count; there is no mid-frame re-sync.
        w_shift_en = 1'b1;
        if (r_cnt == CNT_W'(W - 1)) begin
          w_cnt_nxt   = '0;
`ifdef SERIAL_RX_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PAR: begin
        w_par_en    = 1'b1;
        w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        w_stop_edge = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The outcome is prioritised as frame error, then parity error, then overrun.
    w_frame_bad = w_stop_edge && !serial_in;
`ifdef SERIAL_RX_PARITY_EN
    w_par_bad   = w_stop_edge && serial_in && ((^r_shift) ^ r_par_bit);
`else
    w_par_bad   = 1'b0;
`endif
    w_good      = w_stop_edge && serial_in && !w_par_bad;
    w_accept    = w_good && (!receiver_valid || flush);
    w_overrun   = w_good && receiver_valid && !flush;
  end

  // Datapath: the shift register, output word, valid flag and error pulses.
  // NOTE: the shift register is reset too; it is a plain register, not a memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift          <= '0;
      receiver_valid   <= 1'b0;
      receiver_padding <= '0;
      receiver_packet  <= '0;
      frame_err        <= 1'b0;
      overrun          <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bit        <= 1'b0;
      parity_err       <= 1'b0;
`endif
    end else begin
      frame_err <= w_frame_bad;
      overrun   <= w_overrun;
`ifdef SERIAL_RX_PARITY_EN
      parity_err <= w_par_bad;
      if (w_par_en) begin
        r_par_bit <= serial_in;
      end
`endif
      // LSB first: after W shifts the first bit received sits at r_shift[0].
      if (w_shift_en) begin
        r_shift <= {serial_in, r_shift[W-1:1]};
      end
      if (w_accept) begin
        receiver_valid   <= 1'b1;
        receiver_padding <= r_shift[W-1:PKT_W];
        receiver_packet  <= r_shift[PKT_W-1:0];
      end else if (flush) begin
        receiver_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed, table-driven bench for serial_receiver (PKT_W=42, PAD_W=4).
// Honours SERIAL_RX_PARITY_EN in the same way as the design.
module tb_serial_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic        flush;
  logic        receiver_valid;
  logic [3:0]  receiver_padding;
  logic [41:0] receiver_packet;
  logic        frame_err;
  logic        overrun;
`ifdef SERIAL_RX_PARITY_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the word that should be held on the outputs.
  logic        m_valid;
  logic [3:0]  m_pad;
  logic [41:0] m_pkt;

  serial_receiver #(.PKT_W(42), .PAD_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .serial_in        (serial_in),
    .flush            (flush),
    .receiver_valid   (receiver_valid),
    .receiver_padding (receiver_padding),
    .receiver_packet  (receiver_packet),
    .frame_err        (frame_err),
    .overrun          (overrun)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .parity_err       (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pad;
    logic [41:0] pkt;
    logic        stop_bit;
    logic        flush_at_stop;
    logic        exp_valid;
    logic [3:0]  exp_pad;
    logic [41:0] exp_pkt;
    logic        exp_ferr;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string tag);
    check({tag, " valid"}, 64'(receiver_valid), 64'(m_valid));
    check({tag, " padding"}, 64'(receiver_padding), 64'(m_pad));
    check({tag, " packet"}, 64'(receiver_packet), 64'(m_pkt));
  endtask

  // Drives one bit, lets it be sampled by the next rising edge and returns 1 time unit later.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Sends a full frame. If abort_at >= 0, reset is pulsed right after that data bit.
  task automatic send_frame(input logic [3:0] pad, input logic [41:0] pkt, input logic stop_bit,
                            input logic flush_at_stop, input logic flip_par, input int abort_at);
    logic [45:0] data;
    data = {pad, pkt};
    send_bit(1'b0);
    for (int i = 0; i < 46; i++) begin
      send_bit(data[i]);
      if (i == 20) check_word("mid-frame");
      if (i == abort_at) begin
        rst = 1'b0;
        #2;
        check("abort valid", 64'(receiver_valid), 64'd0);
        check("abort padding", 64'(receiver_padding), 64'd0);
        check("abort packet", 64'(receiver_packet), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        serial_in = 1'b1;
        m_valid = 1'b0; m_pad = '0; m_pkt = '0;
        return;
      end
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^data) ^ flip_par);
`endif
    flush = flush_at_stop;
    send_bit(stop_bit);
    flush     = 1'b0;
    serial_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'hB, 42'h2AC19440329, 1'b1, 1'b0, 1'b1, 4'hB, 42'h2AC19440329, 1'b0, 1'b0};
    vecs[1] = '{4'h0, 42'h00000000001, 1'b1, 1'b0, 1'b1, 4'hB, 42'h2AC19440329, 1'b0, 1'b1};
    vecs[2] = '{4'hF, 42'h3FFFFFFFFFF, 1'b0, 1'b0, 1'b1, 4'hB, 42'h2AC19440329, 1'b1, 1'b0};
    vecs[3] = '{4'h5, 42'h15555555555, 1'b1, 1'b1, 1'b1, 4'h5, 42'h15555555555, 1'b0, 1'b0};
    vecs[4] = '{4'hA, 42'h2AAAAAAAAAA, 1'b1, 1'b0, 1'b1, 4'h5, 42'h15555555555, 1'b0, 1'b1};

    // Reset is held while the line toggles.
    rst = 1'b0; flush = 1'b0; serial_in = 1'b0;
    m_valid = 1'b0; m_pad = '0; m_pkt = '0;
    for (int i = 0; i < 6; i++) send_bit(~serial_in);
    check_word("reset");
    check("reset frame_err", 64'(frame_err), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check_word("idle after reset");

    // Table: good frame, overrun, frame error, flush+accept on the same edge, overrun.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].pad, vecs[v].pkt, vecs[v].stop_bit, vecs[v].flush_at_stop, 1'b0, -1);
      m_valid = vecs[v].exp_valid; m_pad = vecs[v].exp_pad; m_pkt = vecs[v].exp_pkt;
      check_word($sformatf("vec%0d", v));
      check($sformatf("vec%0d frame_err", v), 64'(frame_err), 64'(vecs[v].exp_ferr));
      check($sformatf("vec%0d overrun", v), 64'(overrun), 64'(vecs[v].exp_ovr));
`ifdef SERIAL_RX_PARITY_EN
      check($sformatf("vec%0d parity_err", v), 64'(parity_err), 64'd0);
`endif
      send_bit(1'b1);
      check($sformatf("vec%0d frame_err clears", v), 64'(frame_err), 64'd0);
      check($sformatf("vec%0d overrun clears", v), 64'(overrun), 64'd0);
    end

    // A flush with no frame drops valid and keeps the data.
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    m_valid = 1'b0;
    check_word("flush");
    // A flush while valid is 0 has no effect.
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    check_word("flush idle");

    // The same frame is received twice with a flush between them.
    for (int k = 0; k < 2; k++) begin
      send_frame(4'hB, 42'h2AC19440329, 1'b1, 1'b0, 1'b0, -1);
      m_valid = 1'b1; m_pad = 4'hB; m_pkt = 42'h2AC19440329;
      check_word($sformatf("repeat%0d", k));
      check($sformatf("repeat%0d overrun", k), 64'(overrun), 64'd0);
      flush = 1'b1;
      send_bit(1'b1);
      flush = 1'b0;
      m_valid = 1'b0;
      check_word($sformatf("repeat%0d flushed", k));
    end

    // The first frame is aborted by reset at data bit 20; a clean frame follows.
    m_valid = 1'b0;
    send_frame(4'h3, 42'h0F0F0F0F0F0, 1'b1, 1'b0, 1'b0, 20);
    send_bit(1'b1);
    send_frame(4'h3, 42'h0F0F0F0F0F0, 1'b1, 1'b0, 1'b0, -1);
    m_valid = 1'b1; m_pad = 4'h3; m_pkt = 42'h0F0F0F0F0F0;
    check_word("after abort");
    check("after abort frame_err", 64'(frame_err), 64'd0);

`ifdef SERIAL_RX_PARITY_EN
    // A flipped parity bit raises parity_err and the frame is discarded.
    flush = 1'b1;
    send_bit(1'b1);
    flush = 1'b0;
    m_valid = 1'b0;
    send_frame(4'h9, 42'h12345678ABC, 1'b1, 1'b0, 1'b1, -1);
    check_word("parity bad");
    check("parity bad parity_err", 64'(parity_err), 64'd1);
    check("parity bad frame_err", 64'(frame_err), 64'd0);
    send_bit(1'b1);
    check("parity_err clears", 64'(parity_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
